// File: rtl/noc_router_pkg.sv
// Shared definitions for the parametrised mesh router.
// Holds port indices, flit type encodings, flit field offsets (as functions
// of the flit width) and the output allocator state encoding.
package noc_router_pkg;

  localparam int NPORTS = 5;

  // Port indices; also the bit order of every 5-bit port vector.
  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_W = 3;
  localparam int PORT_S = 4;

  // Flit type field encodings. Bit 0 marks a header, bit 2 marks a tail;
  // a single-flit packet carries both.
  localparam logic [2:0] FLIT_HEAD   = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;
  localparam logic [2:0] FLIT_SINGLE = 3'b101;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  function automatic int type_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int type_lsb(input int dw);
    return dw - 3;
  endfunction

  function automatic int len_msb(input int dw);
    return dw - 4;
  endfunction

  function automatic int len_lsb(input int dw);
    return dw - 15;
  endfunction

  // Destination field starts here and extends downward by 2*COORD_W bits.
  function automatic int dst_msb(input int dw);
    return dw - 16;
  endfunction

endpackage

// File: rtl/noc_fifo_param.sv
// Input FIFO for one router port.
// First-word-fall-through: dout shows the head entry whenever !empty.
// Ports: clk, rst (async, active-high), wr/din (write, ignored when full,
// even if a read happens in the same cycle), rd (pop, ignored when empty),
// dout (head entry), empty, full.
module noc_fifo_param #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]           count_reg;
  logic                  wr_en, rd_en;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;
  assign dout  = mem[rd_ptr_reg];

  // Storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !rd_en)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && rd_en) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/noc_router_mesh.sv
// 5-port wormhole router for a 2D mesh with XY routing.
// Each input has a FIFO; each enabled output has a packet-locked round-robin
// allocator. Packets whose route points to a disabled port are drained.
// Ports (p: 0=L 1=N 2=E 3=W 4=S; bus slice p at [p*DATA_WIDTH +: DATA_WIDTH]):
//   clk, rst       clock, asynchronous active-high reset
//   RX, DRTS, CTS  input link: flit, upstream valid, FIFO not full
//   TX, RTS, DCTS  output link: registered flit, valid pulse, downstream ready
//   err_route      sticky per-input flag: header routed to a disabled port
module noc_router_mesh
  import noc_router_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter int         COORD_W    = 2,
  parameter int         CUR_X      = 0,
  parameter int         CUR_Y      = 0,
  parameter logic [4:0] CX         = 5'b11111
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [5*DATA_WIDTH-1:0]    RX,
  input  logic [4:0]                 DRTS,
  output logic [4:0]                 CTS,
  output logic [5*DATA_WIDTH-1:0]    TX,
  output logic [4:0]                 RTS,
  input  logic [4:0]                 DCTS,
  output logic [4:0]                 err_route
);
  localparam int HDR_BIT  = type_lsb(DATA_WIDTH);
  localparam int TAIL_BIT = type_msb(DATA_WIDTH);
  localparam int DST_MSB  = dst_msb(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] head [NPORTS];
  logic [2:0]            route [NPORTS];
  logic [2:0]            lock_owner [NPORTS];
  logic [2:0]            cur_owner [NPORTS];
  logic [NPORTS-1:0]     empty, full, is_hdr, is_tail;
  logic [NPORTS-1:0]     drop_now, owned, pop, locked, xfer;

  genvar gi;

  // ---------------- input side: FIFO, route computation, drop mode
  for (gi = 0; gi < NPORTS; gi++) begin : g_in
    logic [COORD_W-1:0] dst_x, dst_y;
    logic               drop_reg, err_reg;

    assign CTS[gi] = CX[gi] & ~full[gi];

    noc_fifo_param #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (DRTS[gi] & CTS[gi]),
      .din   (RX[gi*DATA_WIDTH +: DATA_WIDTH]),
      .rd    (pop[gi]),
      .dout  (head[gi]),
      .empty (empty[gi]),
      .full  (full[gi])
    );

    assign is_hdr[gi]  = head[gi][HDR_BIT];
    assign is_tail[gi] = head[gi][TAIL_BIT];
    assign dst_x = head[gi][DST_MSB -: COORD_W];
    assign dst_y = head[gi][DST_MSB-COORD_W -: COORD_W];

    // XY routing: resolve X first, then Y (Y grows southward).
    always_comb begin
      if (int'(dst_x) > CUR_X)      route[gi] = 3'(PORT_E);
      else if (int'(dst_x) < CUR_X) route[gi] = 3'(PORT_W);
      else if (int'(dst_y) > CUR_Y) route[gi] = 3'(PORT_S);
      else if (int'(dst_y) < CUR_Y) route[gi] = 3'(PORT_N);
      else                          route[gi] = 3'(PORT_L);
    end

    // Drain one flit per cycle once a header targets a disabled output,
    // up to and including the packet's tail.
    assign drop_now[gi] = CX[gi] & ~empty[gi] & ~owned[gi] &
                          (drop_reg | (is_hdr[gi] & ~CX[route[gi]]));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        drop_reg <= 1'b0;
        err_reg  <= 1'b0;
      end else if (drop_now[gi]) begin
        drop_reg <= ~is_tail[gi];
        if (!drop_reg) err_reg <= 1'b1;
      end
    end

    assign err_route[gi] = err_reg;
  end

  // ---------------- output side: one allocator per enabled output
  for (gi = 0; gi < NPORTS; gi++) begin : g_out
    if (CX[gi]) begin : g_alloc
      alloc_state_e          state_reg, state_next;
      logic [2:0]            owner_reg, owner_next, rr_reg, rr_next;
      logic [2:0]            pick, sel;
      logic [3:0]            scan;
      logic                  found, xfer_q, rts_reg;
      logic [NPORTS-1:0]     req;
      logic [DATA_WIDTH-1:0] tx_reg;

      always_comb begin
        for (int p = 0; p < NPORTS; p++)
          req[p] = ~empty[p] & is_hdr[p] & ~owned[p] & (route[p] == 3'(gi));

        // Scan from the far end back toward rr_reg so the requester
        // closest to rr_reg (cyclically) is the last one written.
        found = 1'b0;
        pick  = 3'd0;
        scan  = 4'd0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
          scan = {1'b0, rr_reg} + 4'(k);
          if (scan >= 4'(NPORTS)) scan = scan - 4'(NPORTS);
          if (req[scan[2:0]]) begin
            found = 1'b1;
            pick  = scan[2:0];
          end
        end

        sel    = (state_reg == ALLOC_LOCKED) ? owner_reg : pick;
        xfer_q = ((state_reg == ALLOC_LOCKED) | found) & ~empty[sel] & DCTS[gi];

        state_next = state_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        if (state_reg == ALLOC_IDLE && found) begin
          state_next = ALLOC_LOCKED;
          owner_next = pick;
          rr_next    = (pick == 3'(NPORTS - 1)) ? 3'd0 : pick + 3'd1;
        end
        // A tail (including a single-flit header) frees the output in the
        // same cycle it is transferred, even if it was just granted.
        if (xfer_q && is_tail[sel]) state_next = ALLOC_IDLE;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg <= ALLOC_IDLE;
          owner_reg <= 3'd0;
          rr_reg    <= 3'd0;
          tx_reg    <= '0;
          rts_reg   <= 1'b0;
        end else begin
          state_reg <= state_next;
          owner_reg <= owner_next;
          rr_reg    <= rr_next;
          rts_reg   <= xfer_q;
          if (xfer_q) tx_reg <= head[sel];
        end
      end

      assign locked[gi]     = (state_reg == ALLOC_LOCKED);
      assign lock_owner[gi] = owner_reg;
      assign xfer[gi]       = xfer_q;
      assign cur_owner[gi]  = sel;
      assign TX[gi*DATA_WIDTH +: DATA_WIDTH] = tx_reg;
      assign RTS[gi]        = rts_reg;
    end else begin : g_off
      assign locked[gi]     = 1'b0;
      assign lock_owner[gi] = 3'd0;
      assign xfer[gi]       = 1'b0;
      assign cur_owner[gi]  = 3'd0;
      assign TX[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      assign RTS[gi]        = 1'b0;
    end
  end

  // An input locked to some output must not be offered to any other.
  always_comb begin
    owned = '0;
    for (int q = 0; q < NPORTS; q++)
      if (locked[q]) owned[lock_owner[q]] = 1'b1;
  end

  always_comb begin
    pop = drop_now;
    for (int q = 0; q < NPORTS; q++)
      if (xfer[q]) pop[cur_owner[q]] = 1'b1;
  end

endmodule

// File: doc/noc_router_mesh.md
# noc_router_mesh

Parametrised 5-port wormhole router for an arbitrary-size 2D mesh. It generalises the fixed 2x2 router in four ways:
- data width, FIFO depth and coordinate width are parameters;
- the mesh position and port connectivity are parameters;
- output allocation is locked per packet with round-robin fairness;
- packets routed to a disabled port are drained, not deadlocked.

It sits between the network interface (Local port) and up to four neighbouring routers, using the existing RTS/CTS link handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, flit width (≥ 16 + 2*COORD_W)
- FIFO_DEPTH, 4, input FIFO entries per port (power of 2, ≥ 2)
- COORD_W, 2, bits per X/Y coordinate
- CUR_X, 0, this router's X coordinate
- CUR_Y, 0, this router's Y coordinate
- CX, 5'b11111, port-enable mask, bit order {S,W,E,N,L}; L must be 1

Ports (port index p: 0=L, 1=N, 2=E, 3=W, 4=S; packed buses, slice p at [p*DATA_WIDTH +: DATA_WIDTH]):
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- RX  in  5*DATA_WIDTH  incoming flits
- DRTS  in  5  upstream flit valid
- CTS  out  5  input FIFO p not full
- TX  out  5*DATA_WIDTH  outgoing flits, registered
- RTS  out  5  outgoing flit valid, one cycle per flit
- DCTS  in  5  downstream can accept a flit
- err_route  out  5  sticky; bit p = input p received a header for a disabled port

## Operation
Flit fields:
- type [DW-1:DW-3]: 001 header, 010 body, 100 tail. A single-flit packet is a header with bit 2 also set (101).
- length [DW-4:DW-15]: carried through, not checked.
- dst [DW-16 -: 2*COORD_W]: X is the upper half, Y the lower half.

Input side:
- A flit is written when DRTS[p] && CTS[p].
- CTS[p] = !full, from registered state. At full, writes are blocked even in a cycle that also reads.
- A write while CTS is low is ignored.
- Disabled ports: CTS=0, RTS=0, TX=0; their inputs are ignored.

Routing (XY, Y increases southward), evaluated on the FIFO head when it is a header:
- dx > CUR_X → E; dx < CUR_X → W
- otherwise dy > CUR_Y → S; dy < CUR_Y → N
- otherwise → L

Drop mode (target port disabled):
- Input p sets err_route[p] and pops flits with no output until its tail flit, one per cycle.
- It never requests an output.

Output allocator, one per enabled output q, states IDLE and LOCKED:
- IDLE: requesters are inputs whose head is a header routed to q and that are not owned by another output. Grant the first requester at or after rr_ptr[q] (cyclic). Then owner ← p, rr_ptr[q] ← (p+1) mod 5, go to LOCKED. Granting and the first transfer may happen in the same cycle.
- LOCKED: every cycle with owner FIFO non-empty and DCTS[q]=1, pop one flit and register it into TX[q] with RTS[q]=1 next cycle. Otherwise RTS[q]=0 and TX[q] holds.
- On transferring a flit with type bit 2 set (tail), return to IDLE.
- An input is owned by at most one output at a time; flits of different packets never interleave on an output.

## Timing
- Reset (asynchronous, active-high) clears the following. Reset mid-packet discards all in-flight flits; the first flit after reset must be a header.
  - all FIFOs to empty
  - allocators to IDLE, rr_ptr to 0
  - TX = 0, RTS = 0, err_route = 0
  - CTS goes to 1 for enabled ports
- Minimum latency: flit written at edge t; head visible in cycle t+1; granted and popped in t+1; TX/RTS valid in cycle t+2.
- Sustained throughput: one flit per cycle per output while DCTS is held high.
- DCTS is sampled in the cycle of transfer. DCTS low stalls the output; the owner FIFO holds and the lock is retained.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.

## Structure
- Package noc_router_pkg holds:
  - port index constants L/N/E/W/S
  - flit type encodings
  - field offset functions of DATA_WIDTH
  - allocator state encoding
- Sub-module noc_fifo_param (DATA_WIDTH, FIFO_DEPTH; wr, rd, dout, empty, full), instantiated per port in a generate loop.
- Routing, drop logic and the five allocators stay in the top module.

## Test plan
- Single 3-flit packet, defaults (CUR=(0,0)): L→dst (2,0) on L. Required: exits E with RTS on cycles t+2, t+3, t+4, flits unchanged; L_CTS stays 1.
- N and W each send 2-flit packets to dst (0,0) in the same cycle (rr_ptr=0). Required on L: N packet complete, then W packet, with no interleave. A second identical round is also granted N-first, since after W is granted rr_ptr=4 and the scan from 4 wraps to N before W.
- E_DCTS held 0 for 5 cycles mid-packet. Required: no RTS on E; L FIFO fills, L_CTS drops after FIFO_DEPTH further writes. On release, the remaining flits are delivered in order.
- CX=5'b00011 (only L,N), header to dst (1,0). Required: err_route[0]=1; packet drained; RTS all 0; the following packet to (0,0) is delivered on L normally.
- Single-flit packet (type 101) from S. Required: one RTS pulse; lock released in the same cycle, so a second header is granted the next cycle.
- rst asserted mid-packet between clock edges. Required: TX/RTS go to 0 immediately, CTS=1, and a new packet after deassertion routes correctly.
